// File: rtl/undo_stack_unit.sv
// undo_stack_unit: circular undo buffer for the reversible-execution pipeline.
// Pushes come from register read and pops from the reverse-execution path.
// Also provides top-relative peek, checkpoint/rollback, and sticky overflow
// and underflow status.
module undo_stack_unit #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 256,
  parameter int OVERWRITE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic [$clog2(DEPTH)-1:0] peek_off,
  output logic [WIDTH-1:0]         peek_data,
  output logic                     peek_hit,
  input  logic                     mark,
  input  logic                     rollback,
  output logic                     rollback_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW-1:0] ONE_P    = {{(PTRW-1){1'b0}}, 1'b1};
  localparam logic [PTRW:0]   ONE_C    = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW:0]   FULL_CNT = {1'b1, {PTRW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTRW-1:0]  sp_q, sp_d;
  logic [PTRW:0]    count_q, count_d;
  logic [PTRW-1:0]  mark_sp_q, mark_sp_d;
  logic [PTRW:0]    mark_cnt_q, mark_cnt_d;
  logic             mark_valid_q, mark_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             pop_valid_q, pop_valid_d;
  logic             rollback_err_q, rollback_err_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;

  logic             mem_we;
  logic [PTRW-1:0]  mem_waddr;
  logic [PTRW-1:0]  top_ptr;
  logic             is_empty;
  logic             is_full;

  assign top_ptr  = sp_q - ONE_P;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  assign push_ready   = !is_full || (OVERWRITE != 0);
  assign pop_data     = pop_data_q;
  assign pop_valid    = pop_valid_q;
  assign peek_data    = mem_q[sp_q - ONE_P - peek_off];
  assign peek_hit     = ({1'b0, peek_off} < count_q);
  assign rollback_err = rollback_err_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Next-state logic: clear > rollback > (mark combined with push/pop).
  always_comb begin
    sp_d           = sp_q;
    count_d        = count_q;
    mark_sp_d      = mark_sp_q;
    mark_cnt_d     = mark_cnt_q;
    mark_valid_d   = mark_valid_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    pop_valid_d    = 1'b0;
    rollback_err_d = 1'b0;
    pop_data_d     = pop_data_q;
    mem_we         = 1'b0;
    mem_waddr      = sp_q;

    if (clear) begin
      sp_d         = '0;
      count_d      = '0;
      mark_sp_d    = '0;
      mark_cnt_d   = '0;
      mark_valid_d = 1'b1;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      pop_data_d   = '0;
    end else if (rollback) begin
      if (mark_valid_q) begin
        sp_d    = mark_sp_q;
        count_d = mark_cnt_q;
      end else begin
        rollback_err_d = 1'b1;
      end
    end else begin
      // Mark snapshots the pointers as they were before this cycle's push/pop.
      if (mark) begin
        mark_sp_d    = sp_q;
        mark_cnt_d   = count_q;
        mark_valid_d = 1'b1;
      end
      if (pop && !is_empty) begin
        pop_data_d  = mem_q[top_ptr];
        pop_valid_d = 1'b1;
        if (push) begin
          // Swap at the top: depth unchanged.
          mem_we    = 1'b1;
          mem_waddr = top_ptr;
        end else begin
          sp_d    = sp_q - ONE_P;
          count_d = count_q - ONE_C;
        end
      end else begin
        if (pop) begin
          underflow_d = 1'b1;
        end
        if (push) begin
          if (!is_full) begin
            mem_we  = 1'b1;
            sp_d    = sp_q + ONE_P;
            count_d = count_q + ONE_C;
          end else if (OVERWRITE != 0) begin
            // Oldest entry is lost, so any checkpoint may now point at garbage.
            mem_we       = 1'b1;
            sp_d         = sp_q + ONE_P;
            overflow_d   = 1'b1;
            mark_valid_d = 1'b0;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q           <= '0;
      count_q        <= '0;
      mark_sp_q      <= '0;
      mark_cnt_q     <= '0;
      mark_valid_q   <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      pop_valid_q    <= 1'b0;
      rollback_err_q <= 1'b0;
      pop_data_q     <= '0;
    end else begin
      sp_q           <= sp_d;
      count_q        <= count_d;
      mark_sp_q      <= mark_sp_d;
      mark_cnt_q     <= mark_cnt_d;
      mark_valid_q   <= mark_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      pop_valid_q    <= pop_valid_d;
      rollback_err_q <= rollback_err_d;
      pop_data_q     <= pop_data_d;
    end
  end

  // Storage array; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= push_data;
    end
  end

endmodule

// File: tb/tb_undo_stack_unit.sv
// Directed testbench for undo_stack_unit: one default-sized instance plus two
// DEPTH=4 instances (overwrite and refuse policy) sharing the same stimulus.
module tb_undo_stack_unit;

  logic        clk = 1'b0;
  logic        reset, clear, push, pop, mark, rollback;
  logic [15:0] push_data;
  logic [7:0]  peek_off;

  // Main instance (DEPTH=256, OVERWRITE=1)
  logic        push_ready_a, pop_valid_a, peek_hit_a, rollback_err_a;
  logic        empty_a, full_a, overflow_a, underflow_a;
  logic [15:0] pop_data_a, peek_data_a;
  logic [8:0]  count_a;
  // DEPTH=4 overwrite instance
  logic        push_ready_w, pop_valid_w, peek_hit_w, rollback_err_w;
  logic        empty_w, full_w, overflow_w, underflow_w;
  logic [15:0] pop_data_w, peek_data_w;
  logic [2:0]  count_w;
  // DEPTH=4 refuse instance
  logic        push_ready_r, pop_valid_r, peek_hit_r, rollback_err_r;
  logic        empty_r, full_r, overflow_r, underflow_r;
  logic [15:0] pop_data_r, peek_data_r;
  logic [2:0]  count_r;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  undo_stack_unit #(.WIDTH(16), .DEPTH(256), .OVERWRITE(1)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
    .push_ready(push_ready_a), .pop(pop), .pop_data(pop_data_a), .pop_valid(pop_valid_a),
    .peek_off(peek_off), .peek_data(peek_data_a), .peek_hit(peek_hit_a),
    .mark(mark), .rollback(rollback), .rollback_err(rollback_err_a), .count(count_a),
    .empty(empty_a), .full(full_a), .overflow(overflow_a), .underflow(underflow_a));

  undo_stack_unit #(.WIDTH(16), .DEPTH(4), .OVERWRITE(1)) u_w (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
    .push_ready(push_ready_w), .pop(pop), .pop_data(pop_data_w), .pop_valid(pop_valid_w),
    .peek_off(peek_off[1:0]), .peek_data(peek_data_w), .peek_hit(peek_hit_w),
    .mark(mark), .rollback(rollback), .rollback_err(rollback_err_w), .count(count_w),
    .empty(empty_w), .full(full_w), .overflow(overflow_w), .underflow(underflow_w));

  undo_stack_unit #(.WIDTH(16), .DEPTH(4), .OVERWRITE(0)) u_r (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
    .push_ready(push_ready_r), .pop(pop), .pop_data(pop_data_r), .pop_valid(pop_valid_r),
    .peek_off(peek_off[1:0]), .peek_data(peek_data_r), .peek_hit(peek_hit_r),
    .mark(mark), .rollback(rollback), .rollback_err(rollback_err_r), .count(count_r),
    .empty(empty_r), .full(full_r), .overflow(overflow_r), .underflow(underflow_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    mark = 1'b0; rollback = 1'b0; push_data = '0; peek_off = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push1(input logic [15:0] v);
    push = 1'b1; push_data = v;
    exp_q.push_front(v);
    tick();
    push = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_ovf", 32'(overflow_a), 32'd0);
    chk("rst_udf", 32'(underflow_a), 32'd0);
    chk("rst_pvalid", 32'(pop_valid_a), 32'd0);
    chk("rst_pdata", 32'(pop_data_a), 32'd0);
    chk("rst_rberr", 32'(rollback_err_a), 32'd0);
    chk("rst_pready", 32'(push_ready_a), 32'd1);

    // Push three and peek
    push1(16'h1111);
    push1(16'h2222);
    push1(16'h3333);
    chk("p3_count", 32'(count_a), 32'd3);
    peek_off = 8'd0; #1;
    chk("peek0", 32'(peek_data_a), 32'h3333);
    peek_off = 8'd2; #1;
    chk("peek2", 32'(peek_data_a), 32'h1111);
    chk("peek2_hit", 32'(peek_hit_a), 32'd1);
    peek_off = 8'd3; #1;
    chk("peek3_hit", 32'(peek_hit_a), 32'd0);
    peek_off = 8'd0;

    // Four pops: three return data in LIFO order, the fourth underflows
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      tick();
      if (exp_q.size() > 0) begin
        chk("pop_valid", 32'(pop_valid_a), 32'd1);
        chk("pop_data", 32'(pop_data_a), 32'(exp_q.pop_front()));
      end else begin
        chk("pop_empty_valid", 32'(pop_valid_a), 32'd0);
        chk("pop_empty_udf", 32'(underflow_a), 32'd1);
        chk("pop_empty_count", 32'(count_a), 32'd0);
      end
    end
    pop = 1'b0;

    // Full behaviour on DEPTH=4 instances
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      push = 1'b1; push_data = 16'(v);
      tick();
      if (v == 4) begin
        chk("full4_pready_r", 32'(push_ready_r), 32'd0);
        chk("full4_full_r", 32'(full_r), 32'd1);
        chk("full4_pready_w", 32'(push_ready_w), 32'd1);
        chk("full4_ovf_w", 32'(overflow_w), 32'd0);
      end
    end
    push = 1'b0;
    chk("ovw_count", 32'(count_w), 32'd4);
    chk("ovw_ovf", 32'(overflow_w), 32'd1);
    chk("ref_count", 32'(count_r), 32'd4);
    chk("ref_ovf", 32'(overflow_r), 32'd1);
    chk("big_count", 32'(count_a), 32'd5);
    chk("big_ovf", 32'(overflow_a), 32'd0);
    for (int o = 0; o < 4; o++) begin
      peek_off = 8'(o); #1;
      chk("ovw_peek", 32'(peek_data_w), 32'(5 - o));
      chk("ref_peek", 32'(peek_data_r), 32'(4 - o));
    end
    peek_off = 8'd0;

    // Simultaneous push and pop swaps the top entry
    do_reset();
    push1(16'h000A);
    push = 1'b1; pop = 1'b1; push_data = 16'h000B;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("swap_valid", 32'(pop_valid_a), 32'd1);
    chk("swap_data", 32'(pop_data_a), 32'(exp_q.pop_front()));
    chk("swap_count", 32'(count_a), 32'd1);
    peek_off = 8'd0; #1;
    chk("swap_peek", 32'(peek_data_a), 32'h000B);

    // Mark / rollback
    do_reset();
    push1(16'd7);
    mark = 1'b1; tick(); mark = 1'b0;
    push1(16'd8);
    push1(16'd9);
    rollback = 1'b1; tick(); rollback = 1'b0;
    chk("rb_count", 32'(count_a), 32'd1);
    chk("rb_err", 32'(rollback_err_a), 32'd0);
    peek_off = 8'd0; #1;
    chk("rb_peek", 32'(peek_data_a), 32'd7);

    // Mark when full, then overwrite invalidates the checkpoint
    do_reset();
    for (int v = 1; v <= 4; v++) push1(16'(v));
    mark = 1'b1; tick(); mark = 1'b0;
    push1(16'd5);
    rollback = 1'b1; tick(); rollback = 1'b0;
    chk("rbw_err", 32'(rollback_err_w), 32'd1);
    chk("rbw_count", 32'(count_w), 32'd4);
    chk("rbr_err", 32'(rollback_err_r), 32'd0);
    chk("rbr_count", 32'(count_r), 32'd4);
    chk("rba_count", 32'(count_a), 32'd4);
    tick();
    chk("rbw_err_pulse", 32'(rollback_err_w), 32'd0);

    // Clear beats a same-cycle push
    do_reset();
    pop = 1'b1; tick(); pop = 1'b0;
    chk("clr_pre_udf", 32'(underflow_a), 32'd1);
    push1(16'd1);
    push1(16'd2);
    chk("clr_pre_count", 32'(count_a), 32'd2);
    clear = 1'b1; push = 1'b1; push_data = 16'hEEEE;
    tick();
    clear = 1'b0; push = 1'b0;
    chk("clr_count", 32'(count_a), 32'd0);
    chk("clr_empty", 32'(empty_a), 32'd1);
    chk("clr_ovf", 32'(overflow_a), 32'd0);
    chk("clr_udf", 32'(underflow_a), 32'd0);
    peek_off = 8'd0; #1;
    chk("clr_hit", 32'(peek_hit_a), 32'd0);

    // Reset discards an in-flight pop
    push1(16'd5);
    pop = 1'b1; reset = 1'b1;
    tick();
    pop = 1'b0; reset = 1'b0;
    chk("rstpop_valid", 32'(pop_valid_a), 32'd0);
    chk("rstpop_count", 32'(count_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/undo_stack_unit.md
Name: undo_stack_unit

Overview:
- Parametrised, standalone undo buffer for the reversible-execution AXA pipeline. It replaces the fixed 16-bit, 256-entry inline `u` array and its single `usp` pointer.
- Adds:
  - push/pop handshakes;
  - top-relative peek for the undo-typed source operand;
  - checkpoint/rollback for `jerr`-style recovery;
  - a selectable full policy (overwrite oldest vs. refuse);
  - sticky overflow/underflow status.
- Instantiated beside the register-read stage. Pushes come from register read; pops come from the reverse-execution ALU path.

Parameters:
- WIDTH, 16: entry width in bits.
- DEPTH, 256: number of entries; power of two, at least 4.
- PTRW, log2(DEPTH): pointer width; derived, not overridden.
- OVERWRITE, 1: 1 = a push when full overwrites the oldest entry; 0 = a push when full is refused.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of contents and status
- push  in  1  push request
- push_data  in  WIDTH  value to push
- push_ready  out  1  push will be accepted this cycle
- pop  in  1  pop request
- pop_data  out  WIDTH  registered popped value
- pop_valid  out  1  pop_data valid (one-cycle pulse)
- peek_off  in  PTRW  offset from top; 0 = most recent entry
- peek_data  out  WIDTH  combinational entry at top minus peek_off
- peek_hit  out  1  peek_off < count
- mark  in  1  record checkpoint
- rollback  in  1  restore checkpoint
- rollback_err  out  1  registered pulse: rollback target invalid
- count  out  PTRW+1  live entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky
- underflow  out  1  sticky

Behaviour:
- Storage and pointers:
  - Storage is circular. `sp` (PTRW bits) is the next write slot and top = sp-1. All pointer arithmetic is mod DEPTH.
  - `count` saturates at DEPTH.
- Reset / clear:
  - On reset or clear: sp=0, count=0, mark_sp=0, mark_cnt=0, mark_valid=1, overflow=0, underflow=0, pop_valid=0, rollback_err=0, pop_data=0.
  - Storage contents are not cleared.
- Priority per cycle: reset > clear > rollback > mark > push/pop. A lower-priority request in the same cycle is ignored, except that mark and push/pop combine: mark captures state before the push/pop.
- push_ready is combinational and equals !full || OVERWRITE.
- Push only (accepted):
  - mem[sp] <= push_data; sp++.
  - count++ if not full.
  - If full with OVERWRITE=1, count stays DEPTH, overflow <= 1, and the oldest entry is lost.
- Push only (refused): when full with OVERWRITE=0, nothing is written and overflow <= 1.
- Pop only:
  - When count > 0: pop_data <= mem[sp-1]; sp--; count--; pop_valid <= 1 on the next cycle.
  - When empty: pop_valid <= 0, underflow <= 1, state unchanged.
- Push and pop together:
  - When count > 0: pop_data <= old mem[sp-1], then mem[sp-1] <= push_data. sp and count are unchanged; push is always accepted.
  - When empty: underflow <= 1 and the push proceeds as push-only.
- Peek:
  - peek_data = mem[(sp-1-peek_off) mod DEPTH], with zero latency. The value reflects state before this cycle's edge.
  - peek_hit = (peek_off < count).
- Mark:
  - Captures mark_sp <= sp, mark_cnt <= count, mark_valid <= 1.
  - Any later overwrite of an older entry (full push with OVERWRITE=1) clears mark_valid.
  - Pops below the mark leave mark_valid set, but rollback then restores only pointers; data popped and re-pushed is not restored.
- Rollback:
  - If mark_valid: sp <= mark_sp, count <= mark_cnt; no data movement.
  - Otherwise: state unchanged and rollback_err pulses 1 on the next cycle.
- Latency: pop_data, pop_valid and rollback_err are one cycle after the request; all status outputs update on the same edge.
- Reset mid-operation discards any in-flight pop_valid.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 -> count=3; peek_off=0 gives 0x3333, peek_off=2 gives 0x1111; peek_off=3 gives peek_hit=0.
- Pop x4 after the above -> pop_data 0x3333, 0x2222, 0x1111 with pop_valid each cycle; 4th pop gives pop_valid=0, underflow=1, count=0.
- DEPTH=4, OVERWRITE=1: push 1..5 -> count=4, overflow=1; peek offsets 0..3 = 5,4,3,2. Repeat with OVERWRITE=0 -> push_ready=0 after the 4th push, contents 4,3,2,1, overflow=1.
- Push 0xA; push 0xB with simultaneous pop -> pop_data=0xA, count=1, peek_off=0 gives 0xB.
- Push 7, mark, push 8, push 9, rollback -> count=1, peek_off=0 gives 7, no rollback_err. With DEPTH=4, mark when full then push again, rollback -> rollback_err pulses, count unchanged.
- Assert clear and push together with count=2 -> count=0, empty=1, overflow=0, push ignored.
